// File: rtl/multicycle_ctrl_if.sv
// Memory-side bus bundle for multicycle_ctrl.
//   imem_req/imem_addr   : fetch request and address (controller -> imem)
//   imem_gnt             : fetch request accepted (imem -> controller)
//   imem_rvalid/rdata    : fetched instruction return (imem -> controller)
//   dmem_req/dmem_we     : load/store request, 1 = store (controller -> LSU)
//   dmem_done            : load/store completed (LSU -> controller)
interface multicycle_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_done;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_gnt, imem_rvalid, imem_rdata, dmem_done
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_gnt, imem_rvalid, imem_rdata, dmem_done
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multi-cycle RV32 core: fetches over req/gnt/rvalid,
// holds the instruction register, steps EXEC / optional MEM / WB, owns the PC
// and the sticky halt/trap status.
// Ports:
//   clk, rst_n  : core clock, asynchronous active-low reset
//   bus         : imem fetch and dmem load/store handshakes (master side)
//   inst        : instruction register, feeds the decoder
//   opcode      : decoded opcode of inst (combinational from decoder)
//   pc          : current instruction address (also drives imem_addr)
//   next_pc     : branch/jump/sequential target, sampled in EXEC
//   ex_en       : one-cycle execute strobe
//   rf_we       : one-cycle register-file write strobe
//   halt, trap  : sticky stop status; trap marks an error stop
//
// state  | meaning
// FETCH  | imem_req high until imem_gnt
// FWAIT  | waiting for imem_rvalid, bounded by TIMEOUT
// DECODE | decoder settles on inst; illegal/ebreak stop here
// EXEC   | ex_en pulse, next_pc captured
// MEM    | dmem_req high until dmem_done, bounded by TIMEOUT
// WB     | rf_we pulse (not for store/branch), pc <= captured next_pc
// HALT   | terminal; only reset leaves
module multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_ctrl_if.master         bus,
    output logic [31:0]               inst,
    input  logic [6:0]                opcode,
    output logic [31:0]               pc,
    input  logic [31:0]               next_pc,
    output logic                      ex_en,
    output logic                      rf_we,
    output logic                      halt,
    output logic                      trap
);

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Wait timers count down from TIMEOUT-1; reaching zero without a response
    // on the TIMEOUT-th wait cycle is the bus-error condition.
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        FETCH, FWAIT, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    state_t      state;
    logic [7:0]  timer;
    logic [31:0] npc_q;
    logic        imem_req_q;
    logic        dmem_req_q;
    logic        dmem_we_q;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            inst       <= '0;
            timer      <= '0;
            npc_q      <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            ex_en      <= 1'b0;
            rf_we      <= 1'b0;
            halt       <= 1'b0;
            trap       <= 1'b0;
        end else begin
            ex_en <= 1'b0;
            rf_we <= 1'b0;
            case (state)
                FETCH: begin
                    // Reset leaves imem_req low, so the first fetch after reset
                    // spends one cycle raising it; WB raises it for later fetches.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (bus.imem_gnt) begin
                        imem_req_q <= 1'b0;
                        timer      <= TMO_LOAD;
                        if (bus.imem_rvalid) begin
                            inst  <= bus.imem_rdata;
                            state <= DECODE;
                        end else begin
                            state <= FWAIT;
                        end
                    end
                end
                FWAIT: begin
                    if (bus.imem_rvalid) begin
                        inst  <= bus.imem_rdata;
                        state <= DECODE;
                    end else if (timer == 8'd0) begin
                        state <= HALT;
                        halt  <= 1'b1;
                        trap  <= 1'b1;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                DECODE: begin
                    if (!is_legal(opcode)) begin
                        state <= HALT;
                        halt  <= 1'b1;
                        trap  <= 1'b1;
                    end else if (opcode == OP_SYSTEM) begin
                        state <= HALT;
                        halt  <= 1'b1;
                    end else begin
                        state <= EXEC;
                        ex_en <= 1'b1;
                    end
                end
                EXEC: begin
                    npc_q <= next_pc;
                    if (opcode == OP_LOAD || opcode == OP_STORE) begin
                        state      <= MEM;
                        timer      <= TMO_LOAD;
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= (opcode == OP_STORE);
                    end else begin
                        state <= WB;
                        rf_we <= (opcode != OP_BRANCH);
                    end
                end
                MEM: begin
                    if (bus.dmem_done) begin
                        state      <= WB;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        rf_we      <= (opcode != OP_STORE);
                    end else if (timer == 8'd0) begin
                        state      <= HALT;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        halt       <= 1'b1;
                        trap       <= 1'b1;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                WB: begin
                    pc         <= npc_q;
                    state      <= FETCH;
                    imem_req_q <= 1'b1;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                    halt  <= 1'b1;
                    trap  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc;
    assign bus.dmem_req  = dmem_req_q;
    assign bus.dmem_we   = dmem_we_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int          TMO    = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        ex_en;
    logic        rf_we;
    logic        halt;
    logic        trap;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.master),
        .inst    (inst),
        .opcode  (opcode),
        .pc      (pc),
        .next_pc (next_pc),
        .ex_en   (ex_en),
        .rf_we   (rf_we),
        .halt    (halt),
        .trap    (trap)
    );

    // Decoder stand-in: the opcode field of the instruction register.
    assign opcode = inst[6:0];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        model_pc = RST_PC;
    endtask

    // One instruction through the bus. gd: cycles gnt is withheld.
    // rd: FWAIT cycles up to and including rvalid (0 = rvalid with gnt, <0 = never).
    // dd: MEM cycle on which dmem_done is given (0 = never).
    task automatic do_instr(input logic [31:0] instr, input int gd, input int rd,
                            input int dd, input logic [31:0] npc, input bit abort_mem);
        logic [6:0] op;
        bit is_ld, is_st, is_br, is_ebrk, is_ill, is_mem;
        int n, lat, ex_cnt, rf_cnt, req_cnt, we_bad, exp_lat;
        op      = instr[6:0];
        is_ld   = (op == 7'b0000011);
        is_st   = (op == 7'b0100011);
        is_br   = (op == 7'b1100011);
        is_ebrk = (op == 7'b1110011);
        is_mem  = is_ld || is_st;
        is_ill  = !(op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011});
        ex_cnt = 0; rf_cnt = 0; req_cnt = 0; we_bad = 0;

        n = 0;
        while (bus.imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", 32'(bus.imem_req), 32'd1);
        chk("imem_addr", bus.imem_addr, model_pc);
        for (int i = 0; i < gd; i++) @(negedge clk);
        if (gd > 0) chk("req_hold", 32'(bus.imem_req), 32'd1);

        next_pc      = npc;
        bus.imem_gnt = 1'b1;
        if (rd == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = instr;
        end
        @(negedge clk);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        lat = 1;
        chk("req_drop", 32'(bus.imem_req), 32'd0);

        if (rd < 0) begin
            n = 0;
            while (halt !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("fwait_tmo_cycles", 32'(n), 32'(TMO));
            chk("fwait_tmo_halt", 32'(halt), 32'd1);
            chk("fwait_tmo_trap", 32'(trap), 32'd1);
            chk("fwait_tmo_req", 32'(bus.imem_req), 32'd0);
            return;
        end

        for (int i = 1; i <= rd; i++) begin
            if (i == rd) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = instr;
            end
            @(negedge clk);
            lat++;
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end

        while (bus.imem_req !== 1'b1 && halt !== 1'b1 && lat < 64) begin
            if (ex_en === 1'b1) ex_cnt++;
            if (rf_we === 1'b1) rf_cnt++;
            if (bus.dmem_req === 1'b1) begin
                req_cnt++;
                if (bus.dmem_we !== is_st) we_bad++;
                if (abort_mem) begin
                    rst_n = 1'b0;
                    #1;
                    chk("abort_dmem_req", 32'(bus.dmem_req), 32'd0);
                    chk("abort_pc", pc, RST_PC);
                    chk("abort_halt", 32'(halt), 32'd0);
                    @(negedge clk);
                    rst_n    = 1'b1;
                    model_pc = RST_PC;
                    return;
                end
                if (req_cnt == dd) bus.dmem_done = 1'b1;
            end
            @(negedge clk);
            bus.dmem_done = 1'b0;
            lat++;
        end

        chk("inst", inst, instr);
        if (is_ill || is_ebrk) begin
            chk("stop_halt", 32'(halt), 32'd1);
            chk("stop_trap", 32'(trap), 32'(is_ill));
            chk("stop_no_ex", 32'(ex_cnt), 32'd0);
            repeat (3) @(negedge clk);
            chk("stop_req", 32'(bus.imem_req), 32'd0);
            chk("stop_ex", 32'(ex_en), 32'd0);
            chk("stop_pc", pc, model_pc);
        end else if (is_mem && dd == 0) begin
            chk("mem_tmo_halt", 32'(halt), 32'd1);
            chk("mem_tmo_trap", 32'(trap), 32'd1);
            chk("mem_tmo_cycles", 32'(req_cnt), 32'(TMO));
            chk("mem_tmo_req", 32'(bus.dmem_req), 32'd0);
        end else begin
            exp_lat  = 4 + rd + (is_mem ? dd : 0);
            model_pc = npc;
            chk("halt", 32'(halt), 32'd0);
            chk("latency", 32'(lat), 32'(exp_lat));
            chk("ex_en_cnt", 32'(ex_cnt), 32'd1);
            chk("rf_we_cnt", 32'(rf_cnt), 32'((is_st || is_br) ? 0 : 1));
            chk("dmem_req_cnt", 32'(req_cnt), 32'(is_mem ? dd : 0));
            chk("dmem_we", 32'(we_bad), 32'd0);
            chk("pc", pc, model_pc);
        end
    endtask

    logic [31:0] pool [9];
    logic [31:0] rnd_word;
    logic [31:0] word;

    initial begin
        pool[0] = 32'h0050_0093;   // addi
        pool[1] = 32'h0020_81b3;   // add
        pool[2] = 32'h0000_a103;   // lw
        pool[3] = 32'h0011_2023;   // sw
        pool[4] = 32'h0020_8863;   // beq
        pool[5] = 32'h0080_00ef;   // jal
        pool[6] = 32'h0000_80e7;   // jalr
        pool[7] = 32'h1234_52b7;   // lui
        pool[8] = 32'h0000_1317;   // auipc

        rst_n           = 1'b0;
        next_pc         = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.dmem_done   = 1'b0;
        model_pc        = RST_PC;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst", inst, 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_strobes", 32'({ex_en, rf_we}), 32'd0);
        rst_n = 1'b1;

        do_instr(32'h0050_0093, 0, 1, 0, 32'h8000_0004, 1'b0);   // addi
        do_instr(32'h0011_2023, 0, 1, 3, 32'h8000_0008, 1'b0);   // sw, done on 3rd cycle
        do_instr(32'h0020_8863, 1, 2, 0, 32'h8000_0010, 1'b0);   // beq taken
        do_instr(32'h0000_a103, 0, 0, 1, 32'hFFFF_FFFC, 1'b0);   // lw, gnt+rvalid together
        do_instr(32'h0080_00ef, 0, TMO, 0, 32'h0000_0000, 1'b0); // pc wraps to 0; rvalid on last wait cycle

        for (int k = 0; k < 30; k++) begin
            rnd_word = $urandom;
            word     = pool[$urandom_range(0, 8)];
            word     = {rnd_word[31:7], word[6:0]};
            rnd_word = $urandom;
            do_instr(word, $urandom_range(0, 2), $urandom_range(0, TMO),
                     $urandom_range(1, TMO), {rnd_word[31:2], 2'b00}, 1'b0);
        end

        do_instr(32'h0000_a103, 0, 1, 0, 32'h0, 1'b1);           // reset during MEM
        do_instr(32'h0050_0093, 0, 1, 0, 32'h8000_0004, 1'b0);   // restarts from RESET_PC

        do_instr(32'h0010_0073, 0, 1, 0, 32'h0, 1'b0);           // ebreak
        do_reset();
        do_instr(32'hFFFF_FFFF, 0, 1, 0, 32'h0, 1'b0);           // illegal
        do_reset();
        do_instr(32'h0050_0093, 0, -1, 0, 32'h0, 1'b0);          // rvalid never
        do_reset();
        do_instr(32'h0000_a103, 0, 1, 0, 32'h0, 1'b0);           // dmem_done never
        do_reset();
        do_instr(32'h0011_2023, 2, 3, TMO, 32'h8000_0020, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
